// File: rtl/seq_mul_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mul_state_t;

    localparam int MUL_SIZE  = 32;
    localparam int MUL_STEPS = MUL_SIZE / 2;

    function automatic logic rs1_is_signed(input mul_op_t op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input mul_op_t op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/csa_add3.sv
// Three-operand adder: one carry-save compression level followed by a carry-propagate add.
module csa_add3 #(
    parameter int W = 34
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum
);

    logic [W-1:0] s_vec;
    logic [W-1:0] maj_vec;
    logic [W-1:0] c_vec;

    assign s_vec   = a ^ b ^ c;
    assign maj_vec = (a & b) | (a & c) | (b & c);
    // Carries weigh one position higher; the top carry never matters at the widths used here.
    assign c_vec   = {maj_vec[W-2:0], 1'b0};
    assign sum     = s_vec + c_vec;

endmodule

// File: rtl/seq_mul_unit_step.sv
// One radix-4 shift-add step: adds the two partial products selected by two multiplier bits.
module mul_step #(
    parameter int size = 32
) (
    input  logic [size-1:0] acc_hi,
    input  logic [size-1:0] mcand,
    input  logic [1:0]      mbits,
    output logic [size+1:0] acc_hi_nxt,
    output logic [1:0]      lsb_out
);

    logic [size+1:0] base;
    logic [size+1:0] pp0;
    logic [size+1:0] pp1;

    assign base = {2'b00, acc_hi};
    assign pp0  = {2'b00, mcand & {size{mbits[0]}}};
    assign pp1  = {1'b0, mcand & {size{mbits[1]}}, 1'b0};

    // Sum is bounded by 4*(2^size-1), so size+2 bits never overflow.
    csa_add3 #(
        .W(size + 2)
    ) u_csa (
        .a  (base),
        .b  (pp0),
        .c  (pp1),
        .sum(acc_hi_nxt)
    );

    assign lsb_out = acc_hi_nxt[1:0];

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), two multiplier bits retired per cycle.
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int size = MUL_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [size-1:0] rs1,
    input  logic [size-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] result
);

    localparam int STEPS = size / 2;
    localparam int SW    = $clog2(STEPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    function automatic logic [size-1:0] magnitude(input logic [size-1:0] v, input logic is_signed);
        return (is_signed && v[size-1]) ? -v : v;
    endfunction

    function automatic logic [size-1:0] select_half(input logic [2*size-1:0] a, input mul_op_t o);
        return (o == MUL) ? a[size-1:0] : a[2*size-1:size];
    endfunction

    mul_state_t      state;
    mul_op_t         op_q;
    logic            neg_q;
    logic [size-1:0] mcand_q;
    logic [size-1:0] mplier_q;
    logic [2*size-1:0] acc_q;
    logic [SW-1:0]   step_q;

    mul_op_t         op_in;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [size+1:0] step_sum;
    logic [1:0]      step_lsb;

    assign op_in   = mul_op_t'(op);
    assign rs1_neg = rs1_is_signed(op_in) & rs1[size-1];
    assign rs2_neg = rs2_is_signed(op_in) & rs2[size-1];

    mul_step #(
        .size(size)
    ) u_step (
        .acc_hi    (acc_q[2*size-1:size]),
        .mcand     (mcand_q),
        .mbits     (mplier_q[1:0]),
        .acc_hi_nxt(step_sum),
        .lsb_out   (step_lsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            op_q      <= MUL;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            step_q    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_in;
                        mcand_q  <= magnitude(rs1, rs1_is_signed(op_in));
                        mplier_q <= magnitude(rs2, rs2_is_signed(op_in));
                        neg_q    <= rs1_neg ^ rs2_neg;
                        acc_q    <= '0;
                        step_q   <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                // Whole accumulator shifts right by two; the sum's low bits enter the low half.
                CALC: begin
                    acc_q    <= {step_sum[size+1:2], step_lsb, acc_q[size-1:2]};
                    mplier_q <= mplier_q >> 2;
                    step_q   <= step_q + SW'(1);
                    if (step_q == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    acc_q <= neg_q ? -acc_q : acc_q;
                    state <= DONE;
                end
                // First DONE cycle loads the result register; out_valid then holds until taken.
                DONE: begin
                    if (!out_valid) begin
                        result    <= select_half(acc_q, op_q);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
